// File: rtl/dynode_event_packer.sv
// dynode_event_packer: buffers corrected dynode events in a small FIFO and serialises each one
// into a 16-bit word packet on a valid/ready port. Define DYN_PACK_CHECK_EN to add the fourth check word.
module dynode_event_packer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  CHANNEL_ID = 4'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] dyn_enecor,
    input  logic [23:0] dyn_evntim,
    input  logic [7:0]  pulookup,
    input  logic        enecor_load,
    input  logic        rd_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    output logic [6:0]  fifo_count,
    output logic        fifo_full,
    output logic [7:0]  overflow_cnt
);

`ifdef DYN_PACK_CHECK_EN
    localparam int unsigned ENTRY_W = 44;
`else
    localparam int unsigned ENTRY_W = 36;
`endif
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [6:0]  DEPTH_CNT = 7'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_W0 = 3'd1,
        S_W1 = 3'd2,
`ifdef DYN_PACK_CHECK_EN
        S_W2 = 3'd3,
        S_W3 = 3'd4
`else
        S_W2 = 3'd3
`endif
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 run_en;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   head;
    logic                 push;
    logic                 drop;
    logic                 rd_hs;
    logic                 pop;
    logic                 more_events;
    logic [15:0]          word0;
    logic [15:0]          word1;
    logic [15:0]          word2;
`ifdef DYN_PACK_CHECK_EN
    logic [15:0]          word3;
`else
    logic                 unused_tim_lo;
`endif

    // NOTE: reset asserts asynchronously but releases through this flop, so nothing is
    // written until the second edge after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // Fullness comes from the registered count, so a same-cycle pop never makes room.
    assign fifo_full = (fifo_count == DEPTH_CNT);
    assign push      = enecor_load & ~fifo_full & run_en;
    assign drop      = enecor_load &  fifo_full & run_en;
    assign rd_hs     = rd_valid & rd_ready;
    assign pop       = rd_hs & rd_last;
    assign more_events = (fifo_count > 7'd1);

`ifdef DYN_PACK_CHECK_EN
    assign wr_entry = {pulookup, dyn_enecor, dyn_evntim};
`else
    assign wr_entry      = {pulookup, dyn_enecor, dyn_evntim[23:8]};
    assign unused_tim_lo = ^dyn_evntim[7:0];
`endif

    // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 7'd1;
                2'b01:   fifo_count <= fifo_count - 7'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

    // Packet words are formed directly from the head entry.
    assign head  = mem[rd_ptr];
    assign word0 = {4'hA, CHANNEL_ID, head[ENTRY_W-1 -: 8]};
    assign word1 = {4'h0, head[ENTRY_W-9 -: 12]};
    assign word2 = head[ENTRY_W-21 -: 16];
`ifdef DYN_PACK_CHECK_EN
    assign word3 = {head[7:0], 8'h00} ^ word0 ^ word1 ^ word2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fifo_count != 7'd0) state_nxt = S_W0;
            S_W0: if (rd_hs) state_nxt = S_W1;
            S_W1: if (rd_hs) state_nxt = S_W2;
`ifdef DYN_PACK_CHECK_EN
            S_W2: if (rd_hs) state_nxt = S_W3;
            S_W3: if (rd_hs) state_nxt = more_events ? S_W0 : IDLE;
`else
            S_W2: if (rd_hs) state_nxt = more_events ? S_W0 : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_data  = 16'h0000;
        case (state)
            S_W0: begin
                rd_valid = 1'b1;
                rd_data  = word0;
            end
            S_W1: begin
                rd_valid = 1'b1;
                rd_data  = word1;
            end
`ifdef DYN_PACK_CHECK_EN
            S_W2: begin
                rd_valid = 1'b1;
                rd_data  = word2;
            end
            S_W3: begin
                rd_valid = 1'b1;
                rd_last  = 1'b1;
                rd_data  = word3;
            end
`else
            S_W2: begin
                rd_valid = 1'b1;
                rd_last  = 1'b1;
                rd_data  = word2;
            end
`endif
            default: begin
                rd_valid = 1'b0;
                rd_last  = 1'b0;
                rd_data  = 16'h0000;
            end
        endcase
    end

endmodule
